// File: rtl/csa_share_arbiter.sv
// Two-requester round-robin front end sharing one 32-bit carry-select adder.
// Operands are registered on accept, added for one cycle, and returned via a tagged response handshake.
module csa_share_arbiter #(
    parameter bit          FIRST_PRIO = 1'b0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic             req1_sub,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [31:0]      resp_sum,
    output logic             resp_cout,
    output logic             resp_of,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t      state, state_nx;
    logic        last;
    logic [31:0] op_a, op_b;
    logic        op_sub, op_id;
    logic        gnt0, gnt1;

    // Round-robin grant: on contention the requester that did not win last time goes first.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE) begin
            gnt0 = req0_valid & (~req1_valid | last);
            gnt1 = req1_valid & (~req0_valid | ~last);
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (gnt0 | gnt1) state_nx = CALC;
            CALC: state_nx = RESP;
            RESP: if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Carry-select adder: ripple low half, both high-half candidates, select on low carry.
    logic [31:0] add_b;
    logic [16:0] c_lo;
    logic [16:0] c_h0, c_h1;
    logic [15:0] s_lo, s_h0, s_h1;
    logic [31:0] add_sum;
    logic        add_cout, add_of;

    always_comb begin
        add_b   = op_b ^ {32{op_sub}};
        c_lo    = '0;
        c_h0    = '0;
        c_h1    = '0;
        s_lo    = '0;
        s_h0    = '0;
        s_h1    = '0;
        c_lo[0] = op_sub;
        c_h0[0] = 1'b0;
        c_h1[0] = 1'b1;
        for (int unsigned i = 0; i < 16; i++) begin
            s_lo[i]   = op_a[i] ^ add_b[i] ^ c_lo[i];
            c_lo[i+1] = (op_a[i] & add_b[i]) | (c_lo[i] & (op_a[i] ^ add_b[i]));
            s_h0[i]   = op_a[16+i] ^ add_b[16+i] ^ c_h0[i];
            c_h0[i+1] = (op_a[16+i] & add_b[16+i]) | (c_h0[i] & (op_a[16+i] ^ add_b[16+i]));
            s_h1[i]   = op_a[16+i] ^ add_b[16+i] ^ c_h1[i];
            c_h1[i+1] = (op_a[16+i] & add_b[16+i]) | (c_h1[i] & (op_a[16+i] ^ add_b[16+i]));
        end
        if (c_lo[16]) begin
            add_sum  = {s_h1, s_lo};
            add_cout = c_h1[16];
            add_of   = c_h1[16] ^ c_h1[15];
        end else begin
            add_sum  = {s_h0, s_lo};
            add_cout = c_h0[16];
            add_of   = c_h0[16] ^ c_h0[15];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= ~FIRST_PRIO;
            op_a      <= '0;
            op_b      <= '0;
            op_sub    <= 1'b0;
            op_id     <= 1'b0;
            resp_id   <= 1'b0;
            resp_sum  <= '0;
            resp_cout <= 1'b0;
            resp_of   <= 1'b0;
            op_count  <= '0;
        end else begin
            state <= state_nx;
            if (gnt0) begin
                op_a   <= req0_a;
                op_b   <= req0_b;
                op_sub <= req0_sub;
                op_id  <= 1'b0;
                last   <= 1'b0;
            end else if (gnt1) begin
                op_a   <= req1_a;
                op_b   <= req1_b;
                op_sub <= req1_sub;
                op_id  <= 1'b1;
                last   <= 1'b1;
            end
            if (state == CALC) begin
                resp_id   <= op_id;
                resp_sum  <= add_sum;
                resp_cout <= add_cout;
                resp_of   <= add_of;
            end
            if (state == RESP && resp_ready) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

endmodule
